retire_pair_aligner: RTL and testbench
======================================

Name: retire_pair_aligner

Overview:
- Sits directly upstream of the two-run contract checker.
- Takes independent retirement streams from two core instances (run 1, run 2), which may retire the same instruction index in different cycles.
- Buffers each stream and emits strictly paired snapshots (instruction word plus full register file) with a single-cycle retire pulse.
- The checker therefore always compares the N-th retirement of run 1 against the N-th retirement of run 2.
- Flags overflow and excessive skew, then halts.

Parameters:
- DEPTH, 4, entries per side buffer; power of two, >= 2.
- MAX_SKEW, 16, consecutive cycles one side may hold entries while the other is empty before halting.

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- retire_1_i  in  1  run 1 retired an instruction this cycle
- instr_1_i  in  32  run 1 retired instruction word
- regfile_1_i  in  32x32  run 1 register file after retirement
- retire_2_i  in  1  run 2 retire strobe
- instr_2_i  in  32  run 2 retired instruction word
- regfile_2_i  in  32x32  run 2 register file after retirement
- retire_o  out  1  paired retirement valid, one cycle per pair
- instr_1_o  out  32  paired run 1 instruction
- instr_2_o  out  32  paired run 2 instruction
- regfile_1_o  out  32x32  paired run 1 register file
- regfile_2_o  out  32x32  paired run 2 register file
- overflow_o  out  1  sticky: a push was dropped
- skew_err_o  out  1  sticky: skew limit exceeded
- halted_o  out  1  FSM in HALT

Behaviour:
- Reset (async, rst_i=1): all outputs are 0, including instr/regfile outputs. Both buffers are empty with read/write pointers 0. Skew counter is 0. FSM is RUN. Reset mid-operation discards all buffered entries immediately.
- Buffers: one FIFO per side. An entry is {instr, regfile}, captured when retire_x_i=1 at a rising edge. Occupancy counts range 0..DEPTH. Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Pairing rule:
  - Evaluated at each rising edge on the occupancy present before that edge.
  - pop = (state==RUN) && count_1>0 && count_2>0.
  - On pop, both heads are registered into the *_o data outputs and retire_o=1 for exactly the following cycle; otherwise retire_o=0.
  - Data outputs hold their last paired value when retire_o=0.
- Latency: retire inputs sampled at edge k give retire_o high from edge k+1 to edge k+2. Outputs are stable across the negative edge, where the checker samples.
- Throughput: one pair per cycle sustained. Same-side push and pop in one cycle are allowed, including when full: the pop frees the slot and the push succeeds.
- Full: push with count==DEPTH and no same-cycle pop on that side drops the entry and sets overflow_o=1. FSM goes to HALT.
- Skew counter:
  - Increments each cycle where exactly one side has count>0 and the other has count==0.
  - Clears to 0 otherwise, and on any pop.
  - Saturates at MAX_SKEW.
  - When it reaches MAX_SKEW, skew_err_o=1 and FSM goes to HALT.
- FSM, two states:
  - RUN -> HALT on overflow or skew error (both flags may set in the same cycle).
  - HALT: no pushes, no pops, retire_o=0, outputs hold, halted_o=1.
  - HALT exits only through reset.
- Simultaneous events: pushes on both sides with both buffers empty produce a pair on the next edge, not the same edge.

Decomposition:
- Package retire_pair_pkg holds:
  - typedef regfile_t (32x32 logic);
  - typedef retire_entry_t {instr, regfile};
  - FSM enum {RUN, HALT};
  - constant for default DEPTH.
- Sub-module retire_fifo, instantiated twice. It has:
  - push, pop, entry in/out ports;
  - count, full, empty outputs;
  - a drop flag for push-when-full.
- Pairing logic, skew counter and FSM live in the top.

Test Plan:
- Lockstep: retire_1_i=retire_2_i=1 at edge 1 with instr 0x00500093 on both -> retire_o=1 between edges 2 and 3, instr_1_o=instr_2_o=0x00500093, halted_o=0.
- Skew 3: run 1 retires 3 instrs at edges 1-3, run 2 retires the same 3 at edges 4-6 -> retire_o pulses at edges 5,6,7 in order, FIFO order preserved, no flags set.
- Overflow, DEPTH=4: run 1 retires 5 times, run 2 idle -> fifth push dropped, overflow_o=1, halted_o=1, retire_o stays 0 after run 2 later retires.
- Skew timeout, MAX_SKEW=16: one run 1 retire, run 2 idle for 16 cycles -> skew_err_o=1 at the 16th cycle, halted_o=1. A run 2 retire at cycle 15 instead -> no error, one pair emitted.
- Full with same-cycle pop: both sides hold 4 entries, then run 1 pushes while a pair pops -> no overflow, count_1 stays 4, count_2 becomes 3.
- Async reset mid-stream with entries buffered -> all outputs 0 immediately without a clock edge, halted_o=0, and a subsequent lockstep retire pairs normally.

Source files
------------

// File: rtl/retire_pair_pkg.sv
// Shared types for the two-run retirement aligner: snapshot layout, FSM encoding
// and default sizing.
package retire_pair_pkg;

    localparam int DEFAULT_DEPTH    = 4;
    localparam int DEFAULT_MAX_SKEW = 16;

    typedef logic [31:0][31:0] regfile_t;

    typedef struct packed {
        logic [31:0] instr;
        regfile_t    regfile;
    } retire_entry_t;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } fsm_state_e;

endpackage

// File: rtl/retire_fifo.sv
// Per-run retirement buffer. A push into a full buffer succeeds only when the
// same edge pops; otherwise it is dropped and the sticky drop flag is raised.
module retire_fifo
    import retire_pair_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  retire_entry_t    wr_entry,
    output retire_entry_t    rd_entry,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             drop
);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             accept;
    logic             do_pop;
    retire_entry_t    mem [DEPTH];

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign accept   = push && (!full || do_pop);
    assign rd_entry = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            drop   <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({accept, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && !accept) drop <= 1'b1;
        end
    end

    // Storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= wr_entry;
    end

endmodule

// File: rtl/retire_pair_aligner.sv
// Pairs the N-th retirement of run 1 with the N-th retirement of run 2 and
// presents both snapshots with a one-cycle retire pulse; halts on overflow or skew.
module retire_pair_aligner
    import retire_pair_pkg::*;
#(
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int MAX_SKEW = DEFAULT_MAX_SKEW
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        retire_1_i,
    input  logic [31:0] instr_1_i,
    input  regfile_t    regfile_1_i,
    input  logic        retire_2_i,
    input  logic [31:0] instr_2_i,
    input  regfile_t    regfile_2_i,
    output logic        retire_o,
    output logic [31:0] instr_1_o,
    output logic [31:0] instr_2_o,
    output regfile_t    regfile_1_o,
    output regfile_t    regfile_2_o,
    output logic        overflow_o,
    output logic        skew_err_o,
    output logic        halted_o
);

    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int SKEW_W = $clog2(MAX_SKEW + 1);

    function automatic logic [SKEW_W-1:0] sat_inc(input logic [SKEW_W-1:0] v);
        return (v == SKEW_W'(MAX_SKEW)) ? v : v + 1'b1;
    endfunction

    fsm_state_e        state;
    logic              run;
    logic              push_1, push_2, pop;
    logic [CNT_W-1:0]  count_1, count_2;
    logic              full_1, full_2, empty_1, empty_2, drop_1, drop_2;
    logic              one_sided, ovf_evt, skew_evt, skew_err;
    logic [SKEW_W-1:0] skew_cnt, skew_nxt;
    retire_entry_t     in_1_p0, in_2_p0, head_1_p0, head_2_p0;
    retire_entry_t     out_1_p1, out_2_p1;
    logic              vld_p1;

    assign run     = (state == RUN);
    assign push_1  = run && retire_1_i;
    assign push_2  = run && retire_2_i;
    assign pop     = run && (count_1 != '0) && (count_2 != '0);
    assign in_1_p0 = '{instr: instr_1_i, regfile: regfile_1_i};
    assign in_2_p0 = '{instr: instr_2_i, regfile: regfile_2_i};

    retire_fifo #(.DEPTH(DEPTH)) u_fifo_1 (
        .clk      (clk_i),
        .rst      (rst_i),
        .push     (push_1),
        .pop      (pop),
        .wr_entry (in_1_p0),
        .rd_entry (head_1_p0),
        .count    (count_1),
        .full     (full_1),
        .empty    (empty_1),
        .drop     (drop_1)
    );

    retire_fifo #(.DEPTH(DEPTH)) u_fifo_2 (
        .clk      (clk_i),
        .rst      (rst_i),
        .push     (push_2),
        .pop      (pop),
        .wr_entry (in_2_p0),
        .rd_entry (head_2_p0),
        .count    (count_2),
        .full     (full_2),
        .empty    (empty_2),
        .drop     (drop_2)
    );

    assign one_sided = empty_1 ^ empty_2;
    assign ovf_evt   = (push_1 && full_1 && !pop) || (push_2 && full_2 && !pop);

    always_comb begin
        skew_nxt = '0;
        if (one_sided && !pop) skew_nxt = sat_inc(skew_cnt);
    end

    assign skew_evt = run && (skew_nxt == SKEW_W'(MAX_SKEW));

    // p0 -> p1: buffer heads become the paired output snapshot.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= RUN;
            skew_cnt <= '0;
            skew_err <= 1'b0;
            vld_p1   <= 1'b0;
            out_1_p1 <= '0;
            out_2_p1 <= '0;
        end else begin
            vld_p1 <= pop;
            if (pop) begin
                out_1_p1 <= head_1_p0;
                out_2_p1 <= head_2_p0;
            end
            if (run) begin
                skew_cnt <= skew_nxt;
                if (skew_evt) skew_err <= 1'b1;
                if (ovf_evt || skew_evt) state <= HALT;
            end
        end
    end

    assign retire_o    = vld_p1;
    assign instr_1_o   = out_1_p1.instr;
    assign instr_2_o   = out_2_p1.instr;
    assign regfile_1_o = out_1_p1.regfile;
    assign regfile_2_o = out_2_p1.regfile;
    assign overflow_o  = drop_1 | drop_2;
    assign skew_err_o  = skew_err;
    assign halted_o    = (state == HALT);

endmodule

// File: tb/tb_retire_pair_aligner.sv
// Directed bench for retire_pair_aligner with hand-computed expectations.
module tb_retire_pair_aligner;
    import retire_pair_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        retire_1_i, retire_2_i;
    logic [31:0] instr_1_i, instr_2_i;
    regfile_t    regfile_1_i, regfile_2_i;
    logic        retire_o;
    logic [31:0] instr_1_o, instr_2_o;
    regfile_t    regfile_1_o, regfile_2_o;
    logic        overflow_o, skew_err_o, halted_o;

    int checks = 0;
    int errors = 0;
    regfile_t exp_rf;

    retire_pair_aligner dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .retire_1_i  (retire_1_i),
        .instr_1_i   (instr_1_i),
        .regfile_1_i (regfile_1_i),
        .retire_2_i  (retire_2_i),
        .instr_2_i   (instr_2_i),
        .regfile_2_i (regfile_2_i),
        .retire_o    (retire_o),
        .instr_1_o   (instr_1_o),
        .instr_2_o   (instr_2_o),
        .regfile_1_o (regfile_1_o),
        .regfile_2_o (regfile_2_o),
        .overflow_o  (overflow_o),
        .skew_err_o  (skew_err_o),
        .halted_o    (halted_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic regfile_t mkrf(input logic [31:0] s);
        regfile_t rf;
        for (int i = 0; i < 32; i++) rf[i] = s + 32'(i * 7);
        return rf;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of retire inputs, then sample 1 time unit after the edge.
    task automatic cyc(input logic r1, input logic [31:0] i1, input logic r2, input logic [31:0] i2);
        retire_1_i  = r1;
        instr_1_i   = i1;
        regfile_1_i = mkrf(i1);
        retire_2_i  = r2;
        instr_2_i   = i2;
        regfile_2_i = mkrf(i2 ^ 32'h5a5a_0000);
        @(posedge clk_i);
        #1;
        retire_1_i = 1'b0;
        retire_2_i = 1'b0;
    endtask

    task automatic idle();
        cyc(1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic async_reset();
        #2 rst_i = 1'b1;
        #1;
        chk("rst_retire", retire_o, 0);
        chk("rst_instr1", instr_1_o, 0);
        chk("rst_instr2", instr_2_o, 0);
        chk("rst_rf1", regfile_1_o[3], 0);
        chk("rst_ovf", overflow_o, 0);
        chk("rst_skew", skew_err_o, 0);
        chk("rst_halt", halted_o, 0);
        #1 rst_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        retire_1_i = 1'b0; retire_2_i = 1'b0;
        instr_1_i = '0; instr_2_i = '0;
        regfile_1_i = '0; regfile_2_i = '0;
        #12;
        chk("init_retire", retire_o, 0);
        chk("init_instr1", instr_1_o, 0);
        chk("init_halt", halted_o, 0);
        chk("init_ovf", overflow_o, 0);
        chk("init_skew", skew_err_o, 0);
        rst_i = 1'b0;

        // Lockstep pair
        cyc(1'b1, 32'h00500093, 1'b1, 32'h00500093);
        chk("ls_no_same_edge", retire_o, 0);
        idle();
        chk("ls_retire", retire_o, 1);
        chk("ls_instr1", instr_1_o, 32'h00500093);
        chk("ls_instr2", instr_2_o, 32'h00500093);
        exp_rf = mkrf(32'h00500093);
        chk("ls_rf1_r5", regfile_1_o[5], exp_rf[5]);
        exp_rf = mkrf(32'h00500093 ^ 32'h5a5a_0000);
        chk("ls_rf2_r31", regfile_2_o[31], exp_rf[31]);
        chk("ls_halt", halted_o, 0);
        idle();
        chk("ls_pulse_end", retire_o, 0);
        chk("ls_hold", instr_1_o, 32'h00500093);

        // Skew of 3 cycles
        cyc(1'b1, 32'h11, 1'b0, 32'h0);
        cyc(1'b1, 32'h22, 1'b0, 32'h0);
        cyc(1'b1, 32'h33, 1'b0, 32'h0);
        cyc(1'b0, 32'h0, 1'b1, 32'h11);
        chk("sk3_e4", retire_o, 0);
        cyc(1'b0, 32'h0, 1'b1, 32'h22);
        chk("sk3_e5_vld", retire_o, 1);
        chk("sk3_e5_i1", instr_1_o, 32'h11);
        chk("sk3_e5_i2", instr_2_o, 32'h11);
        cyc(1'b0, 32'h0, 1'b1, 32'h33);
        chk("sk3_e6_vld", retire_o, 1);
        chk("sk3_e6_i1", instr_1_o, 32'h22);
        idle();
        chk("sk3_e7_vld", retire_o, 1);
        chk("sk3_e7_i1", instr_1_o, 32'h33);
        chk("sk3_e7_i2", instr_2_o, 32'h33);
        idle();
        chk("sk3_end", retire_o, 0);
        chk("sk3_ovf", overflow_o, 0);
        chk("sk3_skew", skew_err_o, 0);

        // Side 1 full, push while a pair pops
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h100 + 32'(i), 1'b0, 32'h0);
        cyc(1'b0, 32'h0, 1'b1, 32'h200);
        chk("fp_e5_vld", retire_o, 0);
        cyc(1'b1, 32'h104, 1'b0, 32'h0);
        chk("fp_e6_vld", retire_o, 1);
        chk("fp_e6_i1", instr_1_o, 32'h100);
        chk("fp_e6_i2", instr_2_o, 32'h200);
        chk("fp_e6_ovf", overflow_o, 0);
        cyc(1'b0, 32'h0, 1'b1, 32'h201);
        chk("fp_e7_vld", retire_o, 0);
        cyc(1'b0, 32'h0, 1'b1, 32'h202);
        chk("fp_e8_i1", instr_1_o, 32'h101);
        cyc(1'b0, 32'h0, 1'b1, 32'h203);
        chk("fp_e9_i1", instr_1_o, 32'h102);
        cyc(1'b0, 32'h0, 1'b1, 32'h204);
        chk("fp_e10_i1", instr_1_o, 32'h103);
        idle();
        chk("fp_e11_vld", retire_o, 1);
        chk("fp_e11_i1", instr_1_o, 32'h104);
        chk("fp_e11_i2", instr_2_o, 32'h204);
        idle();
        chk("fp_end", retire_o, 0);
        chk("fp_ovf", overflow_o, 0);
        chk("fp_halt", halted_o, 0);

        // Run 2 catches up just inside the skew limit
        cyc(1'b1, 32'h310, 1'b0, 32'h0);
        for (int i = 0; i < 14; i++) idle();
        cyc(1'b0, 32'h0, 1'b1, 32'h310);
        chk("skok_e16_skew", skew_err_o, 0);
        idle();
        chk("skok_vld", retire_o, 1);
        chk("skok_i2", instr_2_o, 32'h310);
        chk("skok_skew", skew_err_o, 0);
        chk("skok_halt", halted_o, 0);

        // Skew timeout
        cyc(1'b1, 32'h300, 1'b0, 32'h0);
        for (int i = 0; i < 15; i++) idle();
        chk("skto_pre_skew", skew_err_o, 0);
        chk("skto_pre_halt", halted_o, 0);
        idle();
        chk("skto_skew", skew_err_o, 1);
        chk("skto_halt", halted_o, 1);
        chk("skto_ovf", overflow_o, 0);
        cyc(1'b0, 32'h0, 1'b1, 32'h300);
        idle();
        chk("skto_no_pair", retire_o, 0);
        chk("skto_hold", instr_1_o, 32'h310);
        async_reset();

        // Overflow with DEPTH=4
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h400 + 32'(i), 1'b0, 32'h0);
        chk("ov_pre_ovf", overflow_o, 0);
        cyc(1'b1, 32'h404, 1'b0, 32'h0);
        chk("ov_ovf", overflow_o, 1);
        chk("ov_halt", halted_o, 1);
        chk("ov_skew", skew_err_o, 0);
        cyc(1'b0, 32'h0, 1'b1, 32'h400);
        idle();
        chk("ov_no_pair", retire_o, 0);
        idle();
        chk("ov_no_pair2", retire_o, 0);

        // Reset with side 1 holding entries, then normal lockstep
        async_reset();
        cyc(1'b1, 32'h00a00113, 1'b1, 32'h00a00113);
        idle();
        chk("post_vld", retire_o, 1);
        chk("post_i1", instr_1_o, 32'h00a00113);
        chk("post_i2", instr_2_o, 32'h00a00113);
        chk("post_halt", halted_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
